// File: rtl/gcd_fsmd_ctrl_pkg.sv
// gcd_fsmd_ctrl_pkg: shared state encoding and default widths for the GCD engine
package gcd_fsmd_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int DEF_W  = 4;
    localparam int DEF_CW = 4;
endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers, saturating step counter, status flags and shared subtractor
// clk, reset            : clock and asynchronous active-high reset
// load, sub_a, sub_b    : capture operands / replace a_reg or b_reg with the difference
// cnt_en                : count one subtraction (saturating)
// a_in, b_in            : operands captured on load
// a_reg, b_reg, cnt     : current operands and step count
// lt, eq, a_zero, b_zero: comparator and zero-test flags for the controller
module gcd_datapath #(
    parameter int W  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          sub_a,
    input  logic          sub_b,
    input  logic          cnt_en,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic [W-1:0]  a_reg,
    output logic [W-1:0]  b_reg,
    output logic [CW-1:0] cnt,
    output logic          lt,
    output logic          eq,
    output logic          a_zero,
    output logic          b_zero
);
    logic [W-1:0] diff;
    assign lt     = a_reg < b_reg;
    assign eq     = a_reg == b_reg;
    assign a_zero = a_reg == '0;
    assign b_zero = b_reg == '0;
    // One subtractor; the larger operand is always the minuend, so no underflow.
    assign diff   = sub_b ? b_reg - a_reg : a_reg - b_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
        end else begin
            a_reg <= load ? a_in : sub_a ? diff : a_reg;
            b_reg <= load ? b_in : sub_b ? diff : b_reg;
            cnt   <= load ? '0 : (cnt_en && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/gcd_fsmd_ctrl.sv
// gcd_fsmd_ctrl: subtractive GCD engine with start/done handshake and step count
// clk, reset        : clock and asynchronous active-high reset
// start, a_in, b_in : request and operands, accepted only while ready
// ready, busy, done : IDLE, CALC and one-cycle DONE indications
// result, steps     : GCD and subtraction count, held until the next accepted start
module gcd_fsmd_ctrl
    import gcd_fsmd_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [CW-1:0] steps
);
    state_t        state, state_nx;
    logic          load, sub_a, sub_b, cnt_en, fin;
    logic          lt, eq, a_zero, b_zero;
    logic [W-1:0]  a_reg, b_reg;
    logic [CW-1:0] cnt;

    gcd_datapath #(.W(W), .CW(CW)) u_dp (
        .clk(clk), .reset(reset), .load(load), .sub_a(sub_a), .sub_b(sub_b),
        .cnt_en(cnt_en), .a_in(a_in), .b_in(b_in), .a_reg(a_reg), .b_reg(b_reg),
        .cnt(cnt), .lt(lt), .eq(eq), .a_zero(a_zero), .b_zero(b_zero)
    );

    assign ready = state == ST_IDLE;
    assign busy  = state == ST_CALC;
    assign done  = state == ST_DONE;

    always_comb begin
        load     = 1'b0;
        sub_a    = 1'b0;
        sub_b    = 1'b0;
        cnt_en   = 1'b0;
        fin      = 1'b0;
        state_nx = ST_IDLE;
        if (state == ST_IDLE) begin
            load     = start;
            state_nx = start ? ST_CALC : ST_IDLE;
        end else if (state == ST_CALC) begin
            fin      = a_zero || b_zero || eq;
            sub_b    = !fin && lt;
            sub_a    = !fin && !lt;
            cnt_en   = !fin;
            state_nx = fin ? ST_DONE : ST_CALC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            result <= '0;
            steps  <= '0;
        end else begin
            state  <= state_nx;
            // a==0 yields b; otherwise a is right for b==0 and for a==b.
            result <= fin ? (a_zero ? b_reg : a_reg) : result;
            steps  <= fin ? cnt : steps;
        end
    end
endmodule
